gpx_hit_writer: RTL and testbench
=================================

GPX_HIT_WRITER -- requirements
Module: gpx_hit_writer

Interface
REQ-001 Parameter MAX_HITS, default 8, SHALL set the maximum hit words stored per shot (range 1..255).
REQ-002 Parameter WINDOW_CYC, default 1000, SHALL set the shot acceptance window length in clk cycles (range 2..65535).
REQ-003 clk  input  1  SHALL be the single clock; all logic is clocked on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 shot_start  input  1  SHALL be a one-cycle pulse marking laser fire.
REQ-006 hit_valid  input  1  SHALL be a one-cycle strobe qualifying hit_data.
REQ-007 hit_data  input  24  SHALL carry the TDC stop result.
REQ-008 frame_ack  input  1  SHALL be a one-cycle pulse from the consumer that releases the held frame.
REQ-009 wre  output  1  SHALL be the write enable to the 512x32 result RAM.
REQ-010 wr_addr  output  9  SHALL be the RAM write address.
REQ-011 wr_data  output  32  SHALL be the RAM write data.
REQ-012 frame_done  output  1  SHALL be a one-cycle pulse marking that the frame is complete.
REQ-013 frame_words  output  10  SHALL give the number of words written in the current frame (0..512).
REQ-014 shot_miss  output  1  SHALL be a sticky flag set when a shot_start is ignored.

Function
REQ-015 States SHALL be IDLE, WINDOW, HDR and HOLD; wre, wr_addr and wr_data SHALL be registered, with wre at 0 in every cycle without a write.
REQ-016 IDLE SHALL behave as follows on shot_start=1: go to WINDOW next cycle, latch base=wr_ptr, set wr_ptr=wr_ptr+1 (header slot reserved), clear hit_cnt, drop and win_cnt.
REQ-017 WINDOW SHALL behave as follows on hit_valid=1 with hit_cnt<MAX_HITS: next cycle wre=1, wr_addr=wr_ptr, wr_data={4'h5, hit_cnt[3:0], hit_data}; then wr_ptr+1 and hit_cnt+1 (latency 1 cycle).
REQ-018 A hit in WINDOW with hit_cnt=MAX_HITS SHALL produce no write and SHALL set drop=1.
REQ-019 In WINDOW, win_cnt SHALL increment every cycle; the cycle with win_cnt=WINDOW_CYC-1 is the last WINDOW cycle, and a hit in that cycle SHALL be accepted; the next state SHALL be HDR.
REQ-020 HDR SHALL last one cycle and write the header: wre=1, wr_addr=base, wr_data={4'hA, drop, 3'b0, hit_cnt[7:0], shot_cnt[15:0]}; shot_cnt SHALL then increment, wrapping 16-bit.
REQ-021 On leaving HDR, if wr_ptr > 511-MAX_HITS the block SHALL go to HOLD and pulse frame_done; otherwise it SHALL go to IDLE.
REQ-022 frame_words SHALL equal wr_ptr (after the HDR write, every reserved slot is written).
REQ-023 HOLD SHALL perform no writes; frame_ack=1 SHALL set wr_ptr=0 and shot_miss=0 and return to IDLE next cycle.
REQ-024 frame_ack outside HOLD SHALL be ignored.
REQ-025 shot_start in WINDOW, HDR or HOLD SHALL be ignored and SHALL set shot_miss=1, with no effect on the current shot.
REQ-026 hit_valid in IDLE, HDR or HOLD SHALL be ignored without setting drop.
REQ-027 shot_start and frame_ack in the same HOLD cycle: the ack SHALL be taken, shot_miss SHALL end at 0, and the shot SHALL be dropped.
REQ-028 wr_ptr SHALL never exceed 512; the HOLD threshold guarantees that one full shot (1+MAX_HITS words) always fits.

Reset
REQ-029 rst=1 SHALL force the following values next cycle, overriding every other input, including mid-WINDOW: state=IDLE, wre=0, wr_addr=0, wr_data=0, frame_done=0, frame_words=0, shot_miss=0, shot_cnt=0, wr_ptr=0; a partial shot is abandoned with its header unwritten.

Verification
REQ-030 With WINDOW_CYC=10: shot_start, then 3 hits with data 0x000111/0x000222/0x000333 SHALL produce writes at addr 1,2,3 of 0x50000111, 0x51000222, 0x52000333, then header at addr 0 of 0xA0030000, with frame_words=4.
REQ-031 With MAX_HITS=2: 4 hits in one window SHALL produce 2 hit writes and a header with drop=1 (0xA8020000 for shot 0).
REQ-032 A hit exactly on the last WINDOW cycle SHALL be written, and the header write SHALL follow in the next-but-one cycle.
REQ-033 Repeated zero-hit shots with MAX_HITS=8 SHALL give frame_done after the shot that leaves wr_ptr=504 (>503); a later shot_start SHALL be ignored with shot_miss=1; frame_ack SHALL give frame_words=0 and shot_miss=0.
REQ-034 rst asserted mid-WINDOW after 2 hits SHALL give wre=0 and state IDLE next cycle; the next shot's header SHALL be written at addr 0 with shot_cnt=0.
REQ-035 shot_start during WINDOW SHALL set shot_miss, with the header hit_cnt unchanged.

Source files
------------

// File: rtl/gpx_hit_writer.sv
// ---------------------------------------------------------------------------
// gpx_hit_writer
//
// Collects TDC stop results (hits) for each laser shot and packs them into a
// 512x32 result RAM as frames of shot records. Each shot record is a header
// word followed by up to MAX_HITS hit words. The header slot is reserved
// when the shot starts and filled in once the acceptance window closes. Only
// then are the final hit count and the overflow (drop) flag known.
//
// When the frame can no longer hold a worst-case shot, the block raises
// frame_done. It then stays in HOLD, ignoring shots, until the consumer
// returns frame_ack.
//
// Parameters
//   MAX_HITS    maximum hit words stored per shot (1..255)
//   WINDOW_CYC  shot acceptance window length in clk cycles (2..65535)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   shot_start   one-cycle pulse: laser fired
//   hit_valid    one-cycle strobe qualifying hit_data
//   hit_data     24-bit TDC stop result
//   frame_ack    one-cycle pulse from consumer releasing a held frame
//   wre          RAM write enable (registered)
//   wr_addr      RAM write address (registered)
//   wr_data      RAM write data (registered)
//   frame_done   one-cycle pulse: frame complete, block now holding
//   frame_words  number of words written in the current frame (0..512)
//   shot_miss    sticky: a shot_start arrived while busy and was ignored
// ---------------------------------------------------------------------------
module gpx_hit_writer #(
  parameter int unsigned MAX_HITS   = 8,
  parameter int unsigned WINDOW_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shot_start,
  input  logic        hit_valid,
  input  logic [23:0] hit_data,
  input  logic        frame_ack,
  output logic        wre,
  output logic [8:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        frame_done,
  output logic [9:0]  frame_words,
  output logic        shot_miss
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    HDR    = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [7:0]  MAX_HITS_C = 8'(MAX_HITS);
  localparam logic [15:0] WIN_LAST   = 16'(WINDOW_CYC - 1);
  // A frame is closed once the next shot (1 header + MAX_HITS hits) might
  // not fit below address 512.
  localparam logic [9:0]  HOLD_LIMIT = 10'(511 - MAX_HITS);

  state_t      state_q, state_d;

  logic [9:0]  wr_ptr_q;    // next free RAM slot; reaches 512 at most
  logic [8:0]  base_q;      // header slot reserved for the current shot
  logic [7:0]  hit_cnt_q;   // hits stored for the current shot
  logic        drop_q;      // at least one hit lost to the MAX_HITS limit
  logic [15:0] win_cnt_q;   // cycles spent in WINDOW
  logic [15:0] shot_cnt_q;  // shots completed since reset, wraps

  // Decoded actions for the current cycle.
  logic accept_shot;
  logic accept_hit;
  logic overflow_hit;
  logic write_hdr;
  logic enter_hold;
  logic take_ack;
  logic miss_set;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and action decode
  // -------------------------------------------------------------------------
  // NOTE: each output of this block is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    accept_shot  = 1'b0;
    accept_hit   = 1'b0;
    overflow_hit = 1'b0;
    write_hdr    = 1'b0;
    enter_hold   = 1'b0;
    take_ack     = 1'b0;
    miss_set     = 1'b0;

    case (state_q)
      IDLE: begin
        if (shot_start) begin
          accept_shot = 1'b1;
          state_d     = WINDOW;
        end
      end

      WINDOW: begin
        miss_set = shot_start;
        if (hit_valid) begin
          if (hit_cnt_q < MAX_HITS_C) begin
            accept_hit = 1'b1;
          end else begin
            overflow_hit = 1'b1;
          end
        end
        // A hit on the final window cycle is still taken above.
        if (win_cnt_q == WIN_LAST) begin
          state_d = HDR;
        end
      end

      HDR: begin
        miss_set  = shot_start;
        write_hdr = 1'b1;
        if (wr_ptr_q > HOLD_LIMIT) begin
          enter_hold = 1'b1;
          state_d    = HOLD;
        end else begin
          state_d = IDLE;
        end
      end

      HOLD: begin
        // An ack wins over a coincident shot_start: the shot is dropped and
        // shot_miss ends cleared.
        if (frame_ack) begin
          take_ack = 1'b1;
          state_d  = IDLE;
        end else begin
          miss_set = shot_start;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and registered RAM port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wre        <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      shot_miss  <= 1'b0;
      wr_ptr_q   <= '0;
      base_q     <= '0;
      hit_cnt_q  <= '0;
      drop_q     <= 1'b0;
      win_cnt_q  <= '0;
      shot_cnt_q <= '0;
    end else begin
      wre        <= 1'b0;
      frame_done <= enter_hold;

      if (accept_shot) begin
        base_q    <= wr_ptr_q[8:0];
        wr_ptr_q  <= wr_ptr_q + 10'd1;
        hit_cnt_q <= '0;
        drop_q    <= 1'b0;
        win_cnt_q <= '0;
      end

      if (state_q == WINDOW) begin
        win_cnt_q <= win_cnt_q + 16'd1;
      end

      if (accept_hit) begin
        wre       <= 1'b1;
        wr_addr   <= wr_ptr_q[8:0];
        wr_data   <= {4'h5, hit_cnt_q[3:0], hit_data};
        wr_ptr_q  <= wr_ptr_q + 10'd1;
        hit_cnt_q <= hit_cnt_q + 8'd1;
      end

      if (overflow_hit) begin
        drop_q <= 1'b1;
      end

      if (write_hdr) begin
        wre        <= 1'b1;
        wr_addr    <= base_q;
        wr_data    <= {4'hA, drop_q, 3'b000, hit_cnt_q, shot_cnt_q};
        shot_cnt_q <= shot_cnt_q + 16'd1;
      end

      if (take_ack) begin
        wr_ptr_q  <= '0;
        shot_miss <= 1'b0;
      end else if (miss_set) begin
        shot_miss <= 1'b1;
      end
    end
  end

  // The header of a finished shot fills its reserved slot, so the write
  // pointer is also the frame length.
  assign frame_words = wr_ptr_q;

endmodule

// File: tb/tb_gpx_hit_writer.sv
// ---------------------------------------------------------------------------
// tb_gpx_hit_writer
//
// Drives shots at the transaction level: one shot is a start pulse, a hit
// pattern across the window, and the header cycle. A shot-level reference
// model predicts every RAM write, with its address, data, frame_done and the
// cycle it must appear in. The predictions go into a queue, and an
// independent monitor compares them with what the DUT presents on its write
// port. Frame length and shot_miss are compared at shot boundaries.
// ---------------------------------------------------------------------------
module tb_gpx_hit_writer;

  localparam int MAX_HITS = 3;
  localparam int WIN      = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        shot_start = 1'b0;
  logic        hit_valid  = 1'b0;
  logic [23:0] hit_data   = '0;
  logic        frame_ack  = 1'b0;
  logic        wre;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic        frame_done;
  logic [9:0]  frame_words;
  logic        shot_miss;

  gpx_hit_writer #(
    .MAX_HITS  (MAX_HITS),
    .WINDOW_CYC(WIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .shot_start (shot_start),
    .hit_valid  (hit_valid),
    .hit_data   (hit_data),
    .frame_ack  (frame_ack),
    .wre        (wre),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_words(frame_words),
    .shot_miss  (shot_miss)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    logic        fd;
    int          when;
  } exp_t;

  exp_t        exp_q[$];
  int          m_ptr  = 0;
  logic [15:0] m_shot = '0;
  bit          m_miss = 0;
  bit          m_hold = 0;
  int          holds  = 0;

  // Inputs set now are sampled at the next edge, and a registered write
  // becomes visible right after it.
  task automatic push(input int addr, input logic [31:0] data, input bit fd);
    exp_t e;
    e.addr = 9'(addr);
    e.data = data;
    e.fd   = fd;
    e.when = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    shot_start = 1'b0;
    hit_valid  = 1'b0;
    frame_ack  = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (wre) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'(wre), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", wr_data, e.data);
        check("frame_done", 32'(frame_done), 32'(e.fd));
        check("write_cycle", 32'(cyc), 32'(e.when));
      end
    end else begin
      if (frame_done) check("frame_done_without_write", 32'(frame_done), 32'd0);
      if (exp_q.size() != 0 && exp_q[0].when <= cyc) begin
        check("write_missing", 32'(wre), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- one shot ----------------
  task automatic run_shot(input logic [WIN-1:0] hits, input logic [WIN-1:0] misses,
                          input bit hdr_noise, input bit seq_data);
    int  base;
    int  n;
    bit  drop;
    bit  fd;
    shot_start = 1'b1;
    hit_valid  = 1'b0;
    frame_ack  = 1'b0;
    step();
    base  = m_ptr;
    m_ptr = m_ptr + 1;
    n     = 0;
    drop  = 0;
    for (int c = 0; c < WIN; c++) begin
      shot_start = misses[c];
      hit_valid  = hits[c];
      hit_data   = seq_data ? 24'(24'h000111 * (n + 1)) : 24'($urandom);
      if (misses[c]) m_miss = 1;
      if (hits[c]) begin
        if (n < MAX_HITS) begin
          push(m_ptr, {4'h5, 4'(n), hit_data}, 1'b0);
          m_ptr = m_ptr + 1;
          n     = n + 1;
        end else begin
          drop = 1;
        end
      end
      step();
    end
    // Header cycle: any shot_start is a miss and any hit is ignored.
    shot_start = hdr_noise;
    hit_valid  = hdr_noise;
    hit_data   = 24'($urandom);
    if (hdr_noise) m_miss = 1;
    fd = (m_ptr > 511 - MAX_HITS);
    push(base, {4'hA, drop, 3'b000, 8'(n), m_shot}, fd);
    m_shot = m_shot + 16'd1;
    step();
    idle_inputs();
    m_hold = fd;
    check("frame_words", 32'(frame_words), 32'(m_ptr));
    check("shot_miss", 32'(shot_miss), 32'(m_miss));
  endtask

  // ---------------- held frame release ----------------
  task automatic hold_phase();
    int n_noise;
    n_noise = $urandom_range(1, 4);
    for (int i = 0; i < n_noise; i++) begin
      shot_start = 1'($urandom_range(0, 1));
      hit_valid  = 1'($urandom_range(0, 1));
      if (shot_start) m_miss = 1;
      step();
    end
    idle_inputs();
    check("hold_shot_miss", 32'(shot_miss), 32'(m_miss));
    check("hold_frame_words", 32'(frame_words), 32'(m_ptr));
    frame_ack  = 1'b1;
    shot_start = 1'($urandom_range(0, 1));
    step();
    idle_inputs();
    m_ptr  = 0;
    m_miss = 0;
    m_hold = 0;
    holds++;
    check("ack_frame_words", 32'(frame_words), 32'd0);
    check("ack_shot_miss", 32'(shot_miss), 32'd0);
  endtask

  // Idle gap between shots; hits and acks here must be ignored.
  task automatic idle_gap();
    int n_gap;
    n_gap = $urandom_range(0, 2);
    for (int i = 0; i < n_gap; i++) begin
      hit_valid = ($urandom_range(0, 3) == 0);
      hit_data  = 24'($urandom);
      frame_ack = ($urandom_range(0, 3) == 0);
      step();
    end
    idle_inputs();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WIN-1:0] hits;
    logic [WIN-1:0] misses;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_wre", 32'(wre), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_words", 32'(frame_words), 32'd0);
    check("rst_shot_miss", 32'(shot_miss), 32'd0);

    // Three hits with sequential data: writes at 1..3, header at 0.
    run_shot(10'b0000000111, '0, 1'b0, 1'b1);
    idle_gap();
    // Five hits against a limit of three: overflow sets drop.
    run_shot(10'b0000011111, '0, 1'b0, 1'b0);
    idle_gap();
    // Single hit on the last window cycle.
    run_shot(10'b1000000000, '0, 1'b0, 1'b0);
    idle_gap();
    // shot_start inside the window is a miss and leaves the shot intact.
    run_shot(10'b0001000010, 10'b0000010000, 1'b0, 1'b0);
    idle_gap();

    // Reset in the middle of a window after two hits.
    shot_start = 1'b1;
    step();
    m_ptr = m_ptr + 1;
    shot_start = 1'b0;
    hit_valid  = 1'b1;
    hit_data   = 24'($urandom);
    push(m_ptr, {4'h5, 4'd0, hit_data}, 1'b0);
    m_ptr = m_ptr + 1;
    step();
    hit_data   = 24'($urandom);
    shot_start = 1'b1;
    m_miss     = 1;
    push(m_ptr, {4'h5, 4'd1, hit_data}, 1'b0);
    m_ptr = m_ptr + 1;
    step();
    shot_start = 1'b0;
    rst        = 1'b1;
    hit_data   = 24'($urandom);
    step();
    rst = 1'b0;
    idle_inputs();
    m_ptr  = 0;
    m_shot = '0;
    m_miss = 0;
    check("midrst_wre", 32'(wre), 32'd0);
    check("midrst_frame_words", 32'(frame_words), 32'd0);
    check("midrst_shot_miss", 32'(shot_miss), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    // Next shot starts immediately, proving the block is back in IDLE.
    run_shot(10'b0000100000, '0, 1'b0, 1'b0);
    idle_gap();

    // Randomised shots until two frames have been filled and released.
    for (int s = 0; s < 1200 && holds < 2; s++) begin
      for (int c = 0; c < WIN; c++) begin
        hits[c]   = ($urandom_range(0, 99) < 30);
        misses[c] = ($urandom_range(0, 99) < 4);
      end
      if ($urandom_range(0, 9) == 0) hits = '0;
      run_shot(hits, misses, ($urandom_range(0, 9) == 0), 1'b0);
      if (m_hold) hold_phase();
      else idle_gap();
    end
    check("frames_completed", 32'(holds), 32'd2);

    repeat (3) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
